// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart transmitter among NREQ byte producers, one byte per grant.
// Ready is combinational in IDLE; each byte is framed by the uart's is_transmitting.
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 0,
    parameter int GUARD      = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    uart_transmit,
    output logic [7:0]              uart_tx_byte,
    input  logic                    uart_is_transmitting,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy
);

    localparam int PW = $clog2(NREQ);
    localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);
    localparam logic [15:0] GUARD_LAST = (GUARD > 1) ? 16'(GUARD - 1) : 16'd0;
    localparam logic [15:0] GAP_LAST   = (GAP_CYCLES > 1) ? 16'(GAP_CYCLES - 1) : 16'd0;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LAUNCH     = 3'd1,
        WAIT_START = 3'd2,
        WAIT_DONE  = 3'd3,
        GAP        = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  ptr_next;
    logic [PW-1:0]  off;
    logic [PW-1:0]  winner;
    logic [PW:0]    sum;
    logic [PW:0]    ptr_inc;
    logic [NREQ-1:0] rot;
    logic           grant;
    logic [15:0]    guard_cnt;
    logic [15:0]    gap_cnt;

    // Rotate the valids so the pointer's requester sits at bit 0; the lowest set
    // bit of the rotated vector is then the round-robin winner's offset.
    assign rot = NREQ'({req_valid, req_valid} >> ptr);

    always_comb begin
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = PW'(i);
            end
        end
    end

    assign sum      = {1'b0, ptr} + {1'b0, off};
    assign winner   = (sum >= NREQ_W) ? PW'(sum - NREQ_W) : PW'(sum);
    assign ptr_inc  = {1'b0, winner} + (PW+1)'(1);
    assign ptr_next = (ptr_inc == NREQ_W) ? '0 : PW'(ptr_inc);

    assign grant         = (state == IDLE) && !uart_is_transmitting && (|req_valid);
    assign req_ready     = grant ? (NREQ'(1) << winner) : '0;
    assign uart_transmit = (state == LAUNCH);
    assign busy          = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT_START;
            end
            WAIT_START: begin
                // A launch the uart never acknowledges is abandoned, not retried.
                if (uart_is_transmitting || (guard_cnt >= GUARD_LAST)) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!uart_is_transmitting) begin
                    state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt >= GAP_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            grant_id     <= '0;
            uart_tx_byte <= 8'h00;
            guard_cnt    <= '0;
            gap_cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                uart_tx_byte <= req_data[8*winner +: 8];
                grant_id     <= winner;
                ptr          <= ptr_next;
            end
            guard_cnt <= (state == WAIT_START) ? guard_cnt + 16'd1 : 16'd0;
            gap_cnt   <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: arbitration table, hand-built multi-cycle corner cases,
// and a randomized run scored against a queue-based round-robin model with a stub uart.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int GAP   = 10;
    localparam int GUARD = 3;
    localparam int FRAME = 6;
    localparam int BUSY_NORMAL = FRAME + GAP + 3;
    localparam int BUSY_DROPPED = GUARD + GAP + 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        uart_transmit;
    logic [7:0]  uart_tx_byte;
    logic        is_tx;
    logic [1:0]  grant_id;
    logic        busy;
    logic        drop;
    logic        force_tx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stub_cnt;
    int double_pulse = 0;
    int min_gap = 1000000;
    int fall_cyc;
    logic fall_seen, prev_stub, prev_tx;
    logic [7:0] launch_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP), .GUARD(GUARD)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
        .uart_is_transmitting(is_tx), .grant_id(grant_id), .busy(busy)
    );

    // Stub uart: busy for FRAME cycles starting the cycle after it sees a launch.
    always @(posedge clk or posedge rst) begin
        if (rst) stub_cnt <= 0;
        else if (uart_transmit && !drop) stub_cnt <= FRAME;
        else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
    end
    assign is_tx = force_tx | (stub_cnt != 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_stub <= 1'b0; prev_tx <= 1'b0; fall_seen <= 1'b0;
        end else begin
            prev_stub <= (stub_cnt != 0);
            prev_tx   <= uart_transmit;
            if (prev_stub && stub_cnt == 0) begin
                fall_seen <= 1'b1; fall_cyc <= cyc;
            end
            if (uart_transmit) begin
                launch_q.push_back(uart_tx_byte);
                if (prev_tx) double_pulse <= double_pulse + 1;
                if (fall_seen) begin
                    if (cyc - fall_cyc < min_gap) min_gap <= cyc - fall_cyc;
                    fall_seen <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge with inputs applied; returns at negedge+1 with ready up.
    task automatic wait_ready(input string name, input int budget);
        int n = 0;
        #1;
        while (req_ready == 4'b0 && n < budget) begin
            @(negedge clk); #1; n++;
        end
        if (req_ready == 4'b0) begin
            total++; bad++;
            $display("FAIL %s: no ready within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk); #1;
        while (busy && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (busy) begin
            total++; bad++;
            $display("FAIL %s: still busy after 200 cycles", name);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_gid;
        logic [7:0]  exp_byte;
    } vec_t;
    vec_t vecs[8];

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rq [NREQ][$];
        logic [7:0] exp_q[$];
        logic [3:0] vld;
        int acc, mptr, free_at, w, hs, left;
        logic [3:0] exp_r;
        bit done;

        vecs[0] = '{4'b0110, 32'h0022_1100, 4'b0010, 2'd1, 8'h11};
        vecs[1] = '{4'b0100, 32'h0022_1100, 4'b0100, 2'd2, 8'h22};
        vecs[2] = '{4'b0001, 32'h0000_00CC, 4'b0001, 2'd0, 8'hCC};
        vecs[3] = '{4'b1001, 32'h3300_0044, 4'b1000, 2'd3, 8'h33};
        vecs[4] = '{4'b1001, 32'h3300_0044, 4'b0001, 2'd0, 8'h44};
        vecs[5] = '{4'b0011, 32'h0000_5566, 4'b0010, 2'd1, 8'h55};
        vecs[6] = '{4'b0001, 32'h0000_0077, 4'b0001, 2'd0, 8'h77};
        vecs[7] = '{4'b1111, 32'h8899_AABB, 4'b0010, 2'd1, 8'hAA};

        rst = 1'b1; req_valid = 4'b0; req_data = 32'h0; drop = 1'b0; force_tx = 1'b0;
        #7;
        check("rst_busy", busy, 0);
        check("rst_transmit", uart_transmit, 0);
        check("rst_tx_byte", uart_tx_byte, 8'h00);
        check("rst_grant_id", grant_id, 0);
        check("rst_ready", req_ready, 0);
        @(negedge clk); rst = 1'b0;

        // Arbitration table: pointer carries over from one vector to the next.
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            req_valid = vecs[v].valid; req_data = vecs[v].data;
            wait_ready("tbl_wait", 100);
            check($sformatf("tbl%0d_ready", v), req_ready, vecs[v].exp_ready);
            @(negedge clk); req_valid = 4'b0; #1;
            check($sformatf("tbl%0d_transmit", v), uart_transmit, 1);
            check($sformatf("tbl%0d_byte", v), uart_tx_byte, vecs[v].exp_byte);
            check($sformatf("tbl%0d_gid", v), grant_id, vecs[v].exp_gid);
            check($sformatf("tbl%0d_busy", v), busy, 1);
        end
        wait_idle("tbl_idle");

        // Saturation: all requesters valid for eight grants.
        pulse_reset();
        launch_q.delete();
        req_valid = 4'b1111; req_data = 32'hA3A2_A1A0;
        hs = 0;
        for (int k = 0; k < 8; k++) begin
            wait_ready("sat_wait", 100);
            check($sformatf("sat%0d_ready", k), req_ready, 4'b0001 << (k % 4));
            if (k > 0) check($sformatf("sat%0d_spacing", k), cyc - hs, BUSY_NORMAL);
            hs = cyc;
            @(negedge clk);
        end
        req_valid = 4'b0;
        wait_idle("sat_idle");
        check("sat_launches", launch_q.size(), 8);
        for (int k = 0; k < 8 && k < launch_q.size(); k++)
            check($sformatf("sat%0d_byte", k), launch_q[k], 8'hA0 + 8'(k % 4));
        check("sat_gap_respected", (min_gap >= GAP), 1);

        // Dropped launch: uart never answers, arbiter moves on after the guard.
        drop = 1'b1;
        @(negedge clk); req_valid = 4'b0011; req_data = 32'h0000_5150;
        wait_ready("guard_wait0", 100);
        check("guard_ready0", req_ready, 4'b0001);
        hs = cyc;
        @(negedge clk); req_valid = 4'b0010;
        wait_ready("guard_wait1", 100);
        check("guard_ready1", req_ready, 4'b0010);
        check("guard_delay", cyc - hs, BUSY_DROPPED);
        drop = 1'b0;
        @(negedge clk); req_valid = 4'b0;
        wait_idle("guard_idle");

        // Reset while the frame is in flight, then check the pointer restarted at 0.
        @(negedge clk); req_valid = 4'b0100; req_data = 32'h0000_0000;
        wait_ready("mid_wait", 100);
        check("mid_ready", req_ready, 4'b0100);
        @(negedge clk); req_valid = 4'b0;
        repeat (4) @(negedge clk);
        #1;
        check("mid_in_frame", is_tx, 1);
        check("mid_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_busy_async", busy, 0);
        check("mid_transmit_async", uart_transmit, 0);
        @(negedge clk); rst = 1'b0;
        req_valid = 4'b1010; req_data = 32'h3300_1100;
        wait_ready("post_wait0", 100);
        check("post_ready0", req_ready, 4'b0010);
        @(negedge clk); req_valid = 4'b1000; #1;
        check("post_gid1", grant_id, 1);
        @(negedge clk);
        wait_ready("post_wait1", 100);
        check("post_ready3", req_ready, 4'b1000);
        @(negedge clk); req_valid = 4'b0; #1;
        check("post_gid3", grant_id, 3);
        check("post_byte3", uart_tx_byte, 8'h33);
        wait_idle("post_idle");

        // uart still transmitting while arbiter is idle: hold off grants.
        @(negedge clk); force_tx = 1'b1; req_valid = 4'b0001; req_data = 32'h0000_00EE;
        for (int k = 0; k < 3; k++) begin
            #1; check($sformatf("hold%0d_ready", k), req_ready, 0);
            @(negedge clk);
        end
        force_tx = 1'b0; #1;
        check("hold_release_ready", req_ready, 4'b0001);
        @(negedge clk); req_valid = 4'b0;
        wait_idle("hold_idle");

        // Randomized traffic against the queue model.
        pulse_reset();
        launch_q.delete();
        for (int i = 0; i < NREQ; i++) begin
            int n = $urandom_range(2, 6);
            for (int j = 0; j < n; j++) rq[i].push_back(8'($urandom));
        end
        vld = 4'b0; acc = -1; mptr = 0; free_at = cyc + 1; done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (acc >= 0) begin
                rq[acc].delete(0); vld[acc] = 1'b0; acc = -1;
            end
            left = 0;
            for (int i = 0; i < NREQ; i++) left += rq[i].size();
            if (left == 0 && cyc >= free_at) begin
                done = 1'b1;
                break;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!vld[i] && rq[i].size() > 0 && $urandom_range(0, 1) == 1) vld[i] = 1'b1;
                else if (vld[i] && $urandom_range(0, 9) == 0) vld[i] = 1'b0;
                req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
            end
            req_valid = vld;
            #1;
            w = (cyc >= free_at) ? rr_pick(vld, mptr) : -1;
            exp_r = (w >= 0) ? (4'b0001 << w) : 4'b0000;
            check("rand_ready", req_ready, exp_r);
            if (w >= 0) begin
                exp_q.push_back(rq[w][0]);
                mptr = (w + 1) % NREQ;
                free_at = cyc + BUSY_NORMAL;
                acc = w;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL rand_timeout: %0d bytes still pending", left);
        end
        req_valid = 4'b0;
        wait_idle("rand_idle");
        check("rand_count", launch_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < launch_q.size(); k++)
            check($sformatf("rand%0d_byte", k), launch_q[k], exp_q[k]);
        check("double_pulse", double_pulse, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
